// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: clears x1..x(NUM_REGS-1) after reset, then
// round-robin arbitrates ALU (A) and load-unit (B) writebacks onto the port.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 5,
    parameter int unsigned NUM_REGS       = 32,
    parameter int unsigned CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rd,
    input  logic [DATA_W-1:0] a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rd,
    input  logic [DATA_W-1:0] b_data,
    output logic              RegWrite,
    output logic [ADDR_W-1:0] write_reg,
    output logic [DATA_W-1:0] write_data,
    output logic              init_done
);

    localparam logic [0:0] CLEAR = 1'b0;
    localparam logic [0:0] RUN   = 1'b1;
    localparam logic [0:0] RESET_STATE = (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
    localparam logic       PRI_A = 1'b0;
    localparam logic       PRI_B = 1'b1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    logic [0:0]        state, state_nxt;
    logic [ADDR_W-1:0] clr_idx, clr_idx_nxt;
    logic              pri, pri_nxt;
    logic              reg_write_nxt;
    logic [ADDR_W-1:0] write_reg_nxt;
    logic [DATA_W-1:0] write_data_nxt;
    logic              init_done_nxt;
    logic              in_run;

    // Grants: only in RUN, contention resolved by the round-robin pointer
    assign in_run  = (state == RUN);
    assign a_ready = in_run & a_valid & (~b_valid | (pri == PRI_A));
    assign b_ready = in_run & b_valid & (~a_valid | (pri == PRI_B));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET_STATE;
            clr_idx    <= ADDR_W'(1);
            pri        <= PRI_A;
            RegWrite   <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            init_done  <= 1'b0;
        end else begin
            state      <= state_nxt;
            clr_idx    <= clr_idx_nxt;
            pri        <= pri_nxt;
            RegWrite   <= reg_write_nxt;
            write_reg  <= write_reg_nxt;
            write_data <= write_data_nxt;
            init_done  <= init_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        clr_idx_nxt    = clr_idx;
        pri_nxt        = pri;
        reg_write_nxt  = 1'b0;
        write_reg_nxt  = write_reg;
        write_data_nxt = write_data;
        init_done_nxt  = init_done;
        case (state)
            CLEAR: begin
                reg_write_nxt  = 1'b1;
                write_reg_nxt  = clr_idx;
                write_data_nxt = '0;
                clr_idx_nxt    = clr_idx + ADDR_W'(1);
                if (clr_idx == LAST_IDX) begin
                    state_nxt     = RUN;
                    init_done_nxt = 1'b1;
                end
            end
            default: begin
                init_done_nxt = 1'b1;
                // x0 writes are accepted but never reach the file
                if (a_ready) begin
                    pri_nxt = PRI_B;
                    if (a_rd != '0) begin
                        reg_write_nxt  = 1'b1;
                        write_reg_nxt  = a_rd;
                        write_data_nxt = a_data;
                    end
                end else if (b_ready) begin
                    pri_nxt = PRI_A;
                    if (b_rd != '0) begin
                        reg_write_nxt  = 1'b1;
                        write_reg_nxt  = b_rd;
                        write_data_nxt = b_data;
                    end
                end
            end
        endcase
    end

endmodule
